hazard_stall_unit: RTL and testbench

//  Stall/flush controller for the 5-stage pipeline. It covers what the EX-stage forwarding path cannot resolve.
//  - Load-use hazard: holds PC and IF/ID, and injects NOP bubbles into ID/EX.
//  - Taken branch resolved in EX/MEM: flushes IF/ID, ID/EX and EX/MEM.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_stall_unit_sat_counter.sv | 24 ++
 rtl/hazard_stall_unit.sv | 101 ++++++++++
 tb/tb_hazard_stall_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard-unit state encoding, WB field layout
// and forwarding-select codes used by the EX-stage forwarding mux.
package pipe_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam int WB_REGWRITE_BIT = 2;

  localparam logic [1:0] FWD_EXMEM = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_NONE  = 2'b10;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; the active-low
// clear is asynchronous so it tracks the pipeline reset directly.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_reg <= '0;
    end else if (en && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipeline,
// with saturating stall/flush counters for performance debug.
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             EXMEM_BrTaken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] REM_INIT = 2'(LOAD_STALL_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [1:0] rem_reg, rem_next;
  logic       hz;

  // $0 is hardwired, so a load "into" it never creates a dependency.
  assign hz = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    if (EXMEM_BrTaken) begin
      state_next = ST_RUN;
      rem_next   = 2'd0;
    end else if (state_reg == ST_STALL) begin
      rem_next = rem_reg - 2'd1;
      if (rem_reg == 2'd1) begin
        state_next = ST_RUN;
      end
    end else if (hz && (LOAD_STALL_CYCLES > 1)) begin
      state_next = ST_STALL;
      rem_next   = REM_INIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_RUN;
      rem_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  // The branch is the older instruction, so it overrides any stall.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (!reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else if (EXMEM_BrTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if ((state_reg == ST_STALL) || hz) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .en    (IDEX_Bubble),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset),
    .en    (EXMEM_BrTaken),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Three hazard units (1, 2 and 3 bubbles per load-use; one with a narrow
// counter) share random stimulus and are checked against a bubble-budget model.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mr = 1'b0, uses = 1'b0, br = 1'b0;
  logic [4:0] ex_rt = '0, rs = '0, rt = '0;

  logic pcw [3];
  logic ifw [3];
  logic bub [3];
  logic iff_o [3];
  logic idf_o [3];
  logic emf_o [3];
  logic [15:0] sc0, fc0, sc2, fc2;
  logic [2:0]  sc1, fc1;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .IDEX_MemRead(mr), .IDEX_Rt(ex_rt),
    .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses), .EXMEM_BrTaken(br),
    .PCWrite(pcw[0]), .IFID_Write(ifw[0]), .IDEX_Bubble(bub[0]),
    .IFID_Flush(iff_o[0]), .IDEX_Flush(idf_o[0]), .EXMEM_Flush(emf_o[0]),
    .stall_count(sc0), .flush_count(fc0));

  hazard_stall_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .IDEX_MemRead(mr), .IDEX_Rt(ex_rt),
    .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses), .EXMEM_BrTaken(br),
    .PCWrite(pcw[1]), .IFID_Write(ifw[1]), .IDEX_Bubble(bub[1]),
    .IFID_Flush(iff_o[1]), .IDEX_Flush(idf_o[1]), .EXMEM_Flush(emf_o[1]),
    .stall_count(sc1), .flush_count(fc1));

  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .IDEX_MemRead(mr), .IDEX_Rt(ex_rt),
    .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses), .EXMEM_BrTaken(br),
    .PCWrite(pcw[2]), .IFID_Write(ifw[2]), .IDEX_Bubble(bub[2]),
    .IFID_Flush(iff_o[2]), .IDEX_Flush(idf_o[2]), .EXMEM_Flush(emf_o[2]),
    .stall_count(sc2), .flush_count(fc2));

  int checks = 0;
  int errors = 0;

  // Model: extra bubbles still owed after the current cycle, plus counters.
  int lsc  [3] = '{1, 2, 3};
  int cmax [3] = '{65535, 7, 65535};
  int owed [3] = '{0, 0, 0};
  int msc  [3] = '{0, 0, 0};
  int mfc  [3] = '{0, 0, 0};

  // Last observed DUT values, used by the directed literal checks.
  int o_pc [3];
  int o_bub[3];
  int o_fl [3];
  int o_sc [3];
  int o_fc [3];

  task automatic chk(input string nm, input int u, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s unit%0d got %0d expected %0d at %0t", nm, u, act, exp, $time);
    end
  endtask

  function automatic int get_sc(input int u);
    case (u)
      0:       return int'(sc0);
      1:       return int'(sc1);
      default: return int'(sc2);
    endcase
  endfunction

  function automatic int get_fc(input int u);
    case (u)
      0:       return int'(fc0);
      1:       return int'(fc1);
      default: return int'(fc2);
    endcase
  endfunction

  task automatic step(input logic r, input logic m, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] c,
                      input logic us, input logic bt);
    bit hz;
    bit stall;
    int e_pc, e_ifw, e_bub, e_fl;
    @(negedge clk);
    reset = r; mr = m; ex_rt = a; rs = b; rt = c; uses = us; br = bt;
    #1;
    hz = m && (a != 0) && ((a == b) || (us && (a == c)));
    for (int u = 0; u < 3; u++) begin
      if (!r) begin
        owed[u] = 0; msc[u] = 0; mfc[u] = 0;
        e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0;
        stall = 1'b0;
      end else if (bt) begin
        e_pc = 1; e_ifw = 1; e_bub = 0; e_fl = 1;
        stall = 1'b0;
      end else begin
        stall = (owed[u] > 0) || hz;
        e_pc = stall ? 0 : 1; e_ifw = e_pc; e_bub = stall ? 1 : 0; e_fl = 0;
      end
      o_pc[u] = int'(pcw[u]); o_bub[u] = int'(bub[u]); o_fl[u] = int'(iff_o[u]);
      o_sc[u] = get_sc(u);    o_fc[u] = get_fc(u);
      chk("pcwrite", u, o_pc[u], e_pc);
      chk("ifid_write", u, int'(ifw[u]), e_ifw);
      chk("idex_bubble", u, o_bub[u], e_bub);
      chk("ifid_flush", u, o_fl[u], e_fl);
      chk("idex_flush", u, int'(idf_o[u]), e_fl);
      chk("exmem_flush", u, int'(emf_o[u]), e_fl);
      chk("stall_count", u, o_sc[u], msc[u]);
      chk("flush_count", u, o_fc[u], mfc[u]);
      if (r) begin
        if (e_bub == 1 && msc[u] < cmax[u]) msc[u]++;
        if (bt && mfc[u] < cmax[u]) mfc[u]++;
        if (bt)               owed[u] = 0;
        else if (owed[u] > 0) owed[u]--;
        else if (hz)          owed[u] = lsc[u] - 1;
      end
    end
    $display("cyc t=%0t rst=%0b mr=%0b rt=%0d rs=%0d irt=%0d uses=%0b br=%0b pc=%0d%0d%0d bub=%0d%0d%0d",
             $time, r, m, a, b, c, us, bt, o_pc[0], o_pc[1], o_pc[2],
             o_bub[0], o_bub[1], o_bub[2]);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  int base;

  initial begin
    // Reset state: frozen pipeline, counters cleared
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    chk("lit_rst_pc", 0, o_pc[0], 0);
    chk("lit_rst_bub", 0, o_bub[0], 1);
    chk("lit_rst_sc", 0, o_sc[0], 0);
    idle();
    chk("lit_run_pc", 0, o_pc[0], 1);

    // 1: load-use via Rs, single bubble
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    chk("lit_t1_pc", 0, o_pc[0], 0);
    chk("lit_t1_bub", 0, o_bub[0], 1);
    idle();
    chk("lit_t1_pc_after", 0, o_pc[0], 1);
    chk("lit_t1_sc", 0, o_sc[0], 1);
    idle(); idle();

    // 2: Rt match only counts when the instruction reads Rt; $0 never stalls
    step(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0);
    chk("lit_t2_nouse", 0, o_bub[0], 0);
    step(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0);
    chk("lit_t2_use", 0, o_bub[0], 1);
    idle(); idle(); idle();
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("lit_t2_zero", 0, o_bub[0], 0);
    chk("lit_t2_zero_u2", 2, o_bub[2], 0);

    // 3: two-bubble unit, hazard on $5
    idle();
    base = o_sc[1];
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("lit_t3_b1", 1, o_bub[1], 1);
    idle();
    chk("lit_t3_b2", 1, o_bub[1], 1);
    idle();
    chk("lit_t3_pc", 1, o_pc[1], 1);
    chk("lit_t3_sc", 1, o_sc[1], base + 2);
    idle();

    // 4: branch and hazard together, branch wins
    base = o_fc[0];
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
    chk("lit_t4_fl", 0, o_fl[0], 1);
    chk("lit_t4_pc", 0, o_pc[0], 1);
    chk("lit_t4_bub", 0, o_bub[0], 0);
    idle();
    chk("lit_t4_fc", 0, o_fc[0], base + 1);

    // 5: branch during the first stall cycle of the three-bubble unit
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1);
    chk("lit_t5_fl", 2, o_fl[2], 1);
    idle();
    chk("lit_t5_pc", 2, o_pc[2], 1);
    chk("lit_t5_bub", 2, o_bub[2], 0);

    // 6: reset mid-stall
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lit_t6_pc", 2, o_pc[2], 0);
    chk("lit_t6_bub", 2, o_bub[2], 1);
    chk("lit_t6_sc", 2, o_sc[2], 0);
    chk("lit_t6_fc", 0, o_fc[0], 0);
    idle();
    chk("lit_t6_run_pc", 2, o_pc[2], 1);
    chk("lit_t6_run_bub", 2, o_bub[2], 0);

    // 7: narrow counter saturates at all-ones under a held hazard
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    chk("lit_t7_sat", 1, o_sc[1], 7);
    chk("lit_t7_wide", 0, o_sc[0], 9);
    idle(); idle(); idle();

    // Randomized traffic on a small register set so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(1) == 1),
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           ($urandom_range(1) == 1), ($urandom_range(7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
